pe_act_broadcast: RTL and testbench
===================================

# pe_act_broadcast

Per-PE activation broadcaster: the producer side of the PE activation queue protocol. On `pe_start_broadcast` it scans the PE's local input activations in the selected activation register-file bank, drops zero values, and emits one `{absolute index, value}` packet per nonzero activation over a valid/ready interface toward the activation network/queue. When the scan is exhausted and every packet has been accepted, it pulses `broadcast_done`, which the PE computation controller uses to leave its pre-broadcast state.

## Interface
- `DATA_WIDTH`, default 16: activation value width.
- `LOCAL_AW`, default 6: local activation address width (entries per PE per layer ≤ 2^LOCAL_AW).
- `PE_IDX_W`, default 6: PE index width. The absolute index width is `LOCAL_AW+PE_IDX_W`.

- `clk`  in  1  system clock.
- `rst`  in  1  reset; one clock, synchronous, active-high.
- `PE_IDX`  in  PE_IDX_W  static PE index.
- `pe_start_broadcast`  in  1  single-cycle start pulse.
- `in_act_no`  in  LOCAL_AW+1  number of local input activations for this layer, 0..2^LOCAL_AW; sampled on start.
- `act_regfile_dir`  in  1  bank select; sampled on start.
- `rd_en`  out  1  register-file read strobe.
- `rd_addr`  out  LOCAL_AW  local read address.
- `rd_dir`  out  1  bank select for the read; equals the latched dir.
- `rd_data`  in  DATA_WIDTH  read data, valid exactly one cycle after `rd_en`.
- `bcast_valid`  out  1  packet valid.
- `bcast_data`  out  LOCAL_AW+PE_IDX_W+DATA_WIDTH  `{rd_addr, PE_IDX, value}`; index in the MSBs, value in the LSBs.
- `bcast_ready`  in  1  downstream accept.
- `broadcast_done`  out  1  one-cycle completion pulse.
- `busy`  out  1  high from the cycle after start until the cycle `broadcast_done` is asserted, inclusive.

## Operation
- States: IDLE, SCAN, DRAIN, DONE.
- IDLE:
  - On `pe_start_broadcast`, latch `in_act_no`, `act_regfile_dir`, and rd_ptr=0.
  - Go to SCAN, or to DONE if `in_act_no`==0.
- SCAN:
  - Issue `rd_en` with `rd_addr`=rd_ptr when `fifo_count + rd_pending - (bcast_valid & bcast_ready) < 2`, then increment rd_ptr.
  - After issuing the read with rd_ptr == in_act_no-1, go to DRAIN.
- Read return (any state): one cycle after `rd_en`, if `rd_data` ≠ 0, push `{addr_d1, PE_IDX, rd_data}` into a 2-entry output FIFO. Zero data is dropped.
- DRAIN: when rd_pending==0 and FIFO empty (after this cycle's pop), go to DONE.
- DONE: assert `broadcast_done` for one cycle, then go to IDLE.
- `bcast_valid` = FIFO non-empty. `bcast_data` = FIFO head. Pop on `bcast_valid & bcast_ready`.
- `pe_start_broadcast` outside IDLE is ignored. No queuing, no restart.
- Index arithmetic: absolute index = rd_addr·2^PE_IDX_W + PE_IDX (concatenation, no adder). rd_ptr is LOCAL_AW+1 bits so 2^LOCAL_AW entries do not wrap.
- The FIFO never overflows; the read-issue rule guarantees it. A push and a pop in the same cycle leave the count unchanged.
- Packet order equals ascending local address.

## Timing
- Reset values: `rd_en`=0, `rd_addr`=0, `rd_dir`=0, `bcast_valid`=0, `bcast_data`=0, `broadcast_done`=0, `busy`=0. State=IDLE, FIFO empty, rd_pending=0.
- Start seen in cycle 0: first `rd_en` in cycle 1, `rd_data` in cycle 2, first `bcast_valid` in cycle 3.
- With `bcast_ready` held high and all values nonzero, throughput is 1 packet/cycle.
- `broadcast_done` is asserted in the cycle after the last handshake, or in the cycle after the last read return if that read returned zero and the FIFO is empty.
- `in_act_no`==0: `broadcast_done` in cycle 1, with no `rd_en`.
- `bcast_valid` stays high, with `bcast_data` stable, until accepted.
- `rst` asserted mid-operation: on the next edge all state clears to reset values, the FIFO empties, and in-flight read data is discarded. No `broadcast_done` is produced.

## Test plan
- PE_IDX=5, in_act_no=4, data {3,0,7,9}, ready=1 -> packets (idx 5, val 3), (idx 133, val 7), (idx 197, val 9). `broadcast_done` one cycle after the last accept. Exactly 4 `rd_en`.
- in_act_no=0 -> no `rd_en`, no `bcast_valid`. `broadcast_done` in cycle 1. `busy` high in cycle 1 only.
- in_act_no=64, all nonzero, ready=1 -> 64 packets on consecutive cycles 3..66. `rd_addr` reaches 63 without wrap. `broadcast_done` in cycle 67.
- in_act_no=8, all nonzero, ready low for 10 cycles after first valid -> at most 2 reads outstanding plus buffered. `bcast_data` stable while stalled. No loss or duplication. In-order after release.
- Second `pe_start_broadcast` in the middle of SCAN with act_regfile_dir toggled -> ignored. `rd_dir` keeps the latched value. A single `broadcast_done`.
- `rst` high for 1 cycle during DRAIN with 2 packets buffered -> next cycle all outputs are at reset values and there is no `broadcast_done`. A new start then behaves normally.

Source files
------------

// File: rtl/pe_act_broadcast.sv
// pe_act_broadcast
// Producer side of the PE activation queue. On a start pulse it walks the
// local input activations of the selected register-file bank, drops zero
// values and emits one {absolute index, value} packet per nonzero entry over
// a valid/ready interface. A 2-entry output FIFO decouples the fixed-latency
// register-file read from downstream backpressure; reads are only issued when
// the FIFO is guaranteed to have room for the returning data.

module pe_act_broadcast #(
  parameter int DATA_WIDTH = 16,
  parameter int LOCAL_AW   = 6,
  parameter int PE_IDX_W   = 6
) (
  input  logic                                     clk,
  input  logic                                     rst,
  input  logic [PE_IDX_W-1:0]                      PE_IDX,
  input  logic                                     pe_start_broadcast,
  input  logic [LOCAL_AW:0]                        in_act_no,
  input  logic                                     act_regfile_dir,
  output logic                                     rd_en,
  output logic [LOCAL_AW-1:0]                      rd_addr,
  output logic                                     rd_dir,
  input  logic [DATA_WIDTH-1:0]                    rd_data,
  output logic                                     bcast_valid,
  output logic [LOCAL_AW+PE_IDX_W+DATA_WIDTH-1:0]  bcast_data,
  input  logic                                     bcast_ready,
  output logic                                     broadcast_done,
  output logic                                     busy
);

  localparam int IDX_W = LOCAL_AW + PE_IDX_W;
  localparam int PKT_W = IDX_W + DATA_WIDTH;
  localparam int CNT_W = LOCAL_AW + 1;

  localparam logic [CNT_W-1:0]      CNT_ZERO  = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0]      CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [DATA_WIDTH-1:0] DATA_ZERO = {DATA_WIDTH{1'b0}};
  localparam logic [PKT_W-1:0]      PKT_ZERO  = {PKT_W{1'b0}};
  localparam logic [LOCAL_AW-1:0]   ADDR_ZERO = {LOCAL_AW{1'b0}};

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SCAN  = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  state_t              state_r;
  state_t              state_s;

  // Job context latched on start
  logic [CNT_W-1:0]    act_no_r;
  logic [CNT_W-1:0]    rd_ptr_r;   // one bit wider than the address so a full bank does not wrap
  logic                dir_r;

  // Read-return pipeline: data arrives one cycle after the strobe
  logic                rd_pending_r;
  logic [LOCAL_AW-1:0] addr_d1_r;

  // 2-entry output FIFO
  logic [PKT_W-1:0]    fifo_mem_r [2];
  logic                fifo_wr_r;
  logic                fifo_rd_r;
  logic [1:0]          fifo_cnt_r;
  logic [1:0]          fifo_cnt_s;

  logic                issue_s;
  logic                last_rd_s;
  logic                push_s;
  logic                pop_s;
  logic [2:0]          occ_s;
  logic                start_s;
  logic [PKT_W-1:0]    push_data_s;

  assign start_s     = (state_r == ST_IDLE) && pe_start_broadcast;
  assign pop_s       = (fifo_cnt_r != 2'd0) && bcast_ready;
  assign push_s      = rd_pending_r && (rd_data != DATA_ZERO);
  // Absolute index is a plain concatenation: local address above the PE index
  assign push_data_s = {addr_d1_r, PE_IDX, rd_data};
  assign last_rd_s   = ((rd_ptr_r + CNT_ONE) == act_no_r);
  // Entries that will eventually occupy the FIFO if nothing else happens
  assign occ_s       = {1'b0, fifo_cnt_r} + {2'b00, rd_pending_r};

  // FIFO occupancy after this cycle's push and pop
  always_comb begin
    fifo_cnt_s = fifo_cnt_r;
    case ({push_s, pop_s})
      2'b10:   fifo_cnt_s = fifo_cnt_r + 2'd1;
      2'b01:   fifo_cnt_s = fifo_cnt_r - 2'd1;
      default: fifo_cnt_s = fifo_cnt_r;
    endcase
  end

  // Next-state and read-issue decision
  always_comb begin
    state_s = state_r;
    issue_s = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (pe_start_broadcast) begin
          if (in_act_no == CNT_ZERO) begin
            state_s = ST_DONE;
          end else begin
            state_s = ST_SCAN;
          end
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_SCAN: begin
        // Only read when the returning word is sure to find a free FIFO slot
        if (occ_s < (3'd2 + {2'b00, pop_s})) begin
          issue_s = 1'b1;
          if (last_rd_s) begin
            state_s = ST_DRAIN;
          end else begin
            state_s = ST_SCAN;
          end
        end else begin
          state_s = ST_SCAN;
        end
      end
      ST_DRAIN: begin
        // No reads are issued here, so nothing is outstanding after this
        // cycle; a final zero return therefore finishes as soon as it lands.
        if (fifo_cnt_s == 2'd0) begin
          state_s = ST_DONE;
        end else begin
          state_s = ST_DRAIN;
        end
      end
      ST_DONE: begin
        state_s = ST_IDLE;
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase
  end

  // State register and job context
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r  <= ST_IDLE;
      act_no_r <= CNT_ZERO;
      rd_ptr_r <= CNT_ZERO;
      dir_r    <= 1'b0;
    end else begin
      state_r <= state_s;
      if (start_s) begin
        act_no_r <= in_act_no;
        dir_r    <= act_regfile_dir;
        rd_ptr_r <= CNT_ZERO;
      end else if (issue_s) begin
        rd_ptr_r <= rd_ptr_r + CNT_ONE;
      end else begin
        rd_ptr_r <= rd_ptr_r;
      end
    end
  end

  // Track the read in flight and the address it belongs to
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_pending_r <= 1'b0;
      addr_d1_r    <= ADDR_ZERO;
    end else begin
      rd_pending_r <= issue_s;
      if (issue_s) begin
        addr_d1_r <= rd_ptr_r[LOCAL_AW-1:0];
      end else begin
        addr_d1_r <= addr_d1_r;
      end
    end
  end

  // Output FIFO storage and pointers
  always_ff @(posedge clk) begin
    if (rst) begin
      fifo_mem_r[0] <= PKT_ZERO;
      fifo_mem_r[1] <= PKT_ZERO;
      fifo_wr_r     <= 1'b0;
      fifo_rd_r     <= 1'b0;
      fifo_cnt_r    <= 2'd0;
    end else begin
      if (push_s) begin
        fifo_mem_r[fifo_wr_r] <= push_data_s;
        fifo_wr_r             <= ~fifo_wr_r;
      end else begin
        fifo_wr_r <= fifo_wr_r;
      end
      if (pop_s) begin
        fifo_rd_r <= ~fifo_rd_r;
      end else begin
        fifo_rd_r <= fifo_rd_r;
      end
      fifo_cnt_r <= fifo_cnt_s;
    end
  end

  assign rd_en          = issue_s;
  assign rd_addr        = rd_ptr_r[LOCAL_AW-1:0];
  assign rd_dir         = dir_r;
  assign bcast_valid    = (fifo_cnt_r != 2'd0);
  assign bcast_data     = bcast_valid ? fifo_mem_r[fifo_rd_r] : PKT_ZERO;
  assign broadcast_done = (state_r == ST_DONE);
  assign busy           = (state_r != ST_IDLE);

endmodule

// File: tb/tb_pe_act_broadcast.sv
// Self-checking bench for pe_act_broadcast: table of broadcast jobs with
// expected timing, a scoreboard queue of expected packets filled when the
// register-file contents are set up, plus hand-written reset sequences.

module tb_pe_act_broadcast;

  localparam int DW    = 16;
  localparam int LAW   = 6;
  localparam int PIW   = 6;
  localparam int PKT_W = LAW + PIW + DW;

  logic              clk = 1'b0;
  logic              rst;
  logic [PIW-1:0]    pe_idx;
  logic              pe_start_broadcast;
  logic [LAW:0]      in_act_no;
  logic              act_regfile_dir;
  logic              rd_en;
  logic [LAW-1:0]    rd_addr;
  logic              rd_dir;
  logic [DW-1:0]     rd_data;
  logic              bcast_valid;
  logic [PKT_W-1:0]  bcast_data;
  logic              bcast_ready;
  logic              broadcast_done;
  logic              busy;

  always #5 clk = ~clk;

  pe_act_broadcast #(.DATA_WIDTH(DW), .LOCAL_AW(LAW), .PE_IDX_W(PIW)) dut (
    .clk(clk), .rst(rst), .PE_IDX(pe_idx),
    .pe_start_broadcast(pe_start_broadcast), .in_act_no(in_act_no),
    .act_regfile_dir(act_regfile_dir), .rd_en(rd_en), .rd_addr(rd_addr),
    .rd_dir(rd_dir), .rd_data(rd_data), .bcast_valid(bcast_valid),
    .bcast_data(bcast_data), .bcast_ready(bcast_ready),
    .broadcast_done(broadcast_done), .busy(busy)
  );

  // Register-file model: two banks, one-cycle read latency, junk when idle
  logic [DW-1:0] bank0 [64];
  logic [DW-1:0] bank1 [64];
  always @(posedge clk) begin
    rd_data <= rd_en ? (rd_dir ? bank1[rd_addr] : bank0[rd_addr]) : 16'hDEAD;
  end

  int errors = 0;
  int checks = 0;
  logic [PKT_W-1:0] exp_q [$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=%0d required=%0d", name, act, exp);
    end
  endtask

  function automatic logic [DW-1:0] pat_val(input int pat, input int i);
    logic [DW-1:0] p0 [4];
    logic [DW-1:0] p3 [3];
    p0 = '{16'd3, 16'd0, 16'd7, 16'd9};
    p3 = '{16'd5, 16'd6, 16'd0};
    case (pat)
      0:       return (i < 4) ? p0[i] : 16'd1;
      1:       return 16'(i * 37 + 1);
      2:       return (i % 3 == 1) ? 16'd0 : 16'(i + 100);
      3:       return (i < 3) ? p3[i] : 16'd1;
      default: return 16'd1;
    endcase
  endfunction

  // pe, n, dir, pat, stall_from, stall_len, restart_cyc, exp_done, exp_rd, exp_first, exp_pkts
  typedef struct {
    int pe; int n; bit dir; int pat;
    int stall_from; int stall_len; int restart_cyc;
    int exp_done; int exp_rd; int exp_first; int exp_pkts;
  } vec_t;

  vec_t vecs [7];

  task automatic fill_banks(input vec_t v);
    for (int i = 0; i < 64; i++) begin
      logic [DW-1:0] d;
      d = pat_val(v.pat, i);
      if (v.dir) begin
        bank1[i] = d;
        bank0[i] = 16'hBEEF + 16'(i);
      end else begin
        bank0[i] = d;
        bank1[i] = 16'hBEEF + 16'(i);
      end
    end
  endtask

  task automatic run_case(input vec_t v, input string tag);
    int rd_cnt, pkts, first, done_cyc, max_addr;
    bit busy_ok, dir_ok, stable_ok, out_ok, prev_stall, quiet_ok;
    logic [PKT_W-1:0] prev_data, expd;
    rd_cnt = 0; pkts = 0; first = 0; done_cyc = 0; max_addr = 0;
    busy_ok = 1'b1; dir_ok = 1'b1; stable_ok = 1'b1; out_ok = 1'b1;
    prev_stall = 1'b0; prev_data = '0;
    fill_banks(v);
    exp_q.delete();
    for (int i = 0; i < v.n; i++) begin
      if (pat_val(v.pat, i) != 16'd0)
        exp_q.push_back({6'(i), 6'(v.pe), pat_val(v.pat, i)});
    end
    @(negedge clk);
    pe_idx = 6'(v.pe); in_act_no = 7'(v.n); act_regfile_dir = v.dir;
    pe_start_broadcast = 1'b1; bcast_ready = 1'b1;
    for (int cyc = 1; cyc <= 200 && done_cyc == 0; cyc++) begin
      @(negedge clk);
      pe_start_broadcast = (v.restart_cyc == cyc);
      if (v.restart_cyc == cyc) begin
        in_act_no = 7'd3; act_regfile_dir = ~v.dir;
      end else begin
        in_act_no = 7'(v.n); act_regfile_dir = v.dir;
      end
      bcast_ready = !(cyc >= v.stall_from && cyc < v.stall_from + v.stall_len);
      #1;
      if (!busy) busy_ok = 1'b0;
      if (rd_en) begin
        rd_cnt++;
        if (rd_dir !== v.dir) dir_ok = 1'b0;
        if (int'(rd_addr) > max_addr) max_addr = int'(rd_addr);
      end
      if (prev_stall && (!bcast_valid || bcast_data !== prev_data)) stable_ok = 1'b0;
      if (bcast_valid && first == 0) first = cyc;
      if (bcast_valid && bcast_ready) begin
        pkts++;
        if (exp_q.size() == 0) begin
          check({tag, "_extra_pkt"}, 64'(bcast_data), 64'd0);
        end else begin
          expd = exp_q.pop_front();
          check({tag, "_pkt"}, 64'(bcast_data), 64'(expd));
        end
      end
      prev_stall = bcast_valid && !bcast_ready;
      prev_data = bcast_data;
      if (v.pat == 1 && rd_cnt - pkts > 2) out_ok = 1'b0;
      if (broadcast_done) done_cyc = cyc;
    end
    check({tag, "_done_cycle"}, 64'(done_cyc), 64'(v.exp_done));
    check({tag, "_rd_count"}, 64'(rd_cnt), 64'(v.exp_rd));
    check({tag, "_pkt_count"}, 64'(pkts), 64'(v.exp_pkts));
    check({tag, "_first_valid"}, 64'(first), 64'(v.exp_first));
    check({tag, "_busy"}, 64'(busy_ok), 64'd1);
    check({tag, "_rd_dir"}, 64'(dir_ok), 64'd1);
    check({tag, "_stable"}, 64'(stable_ok), 64'd1);
    check({tag, "_outstanding"}, 64'(out_ok), 64'd1);
    check({tag, "_left_in_q"}, 64'(exp_q.size()), 64'd0);
    if (v.n > 0) check({tag, "_max_addr"}, 64'(max_addr), 64'(v.n - 1));
    quiet_ok = 1'b1;
    bcast_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk); #1;
      if (broadcast_done || busy || rd_en || bcast_valid) quiet_ok = 1'b0;
    end
    check({tag, "_quiet_after"}, 64'(quiet_ok), 64'd1);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_rd_en"}, 64'(rd_en), 64'd0);
    check({tag, "_rd_addr"}, 64'(rd_addr), 64'd0);
    check({tag, "_rd_dir"}, 64'(rd_dir), 64'd0);
    check({tag, "_valid"}, 64'(bcast_valid), 64'd0);
    check({tag, "_data"}, 64'(bcast_data), 64'd0);
    check({tag, "_done"}, 64'(broadcast_done), 64'd0);
    check({tag, "_busy"}, 64'(busy), 64'd0);
  endtask

  initial begin
    bit seen_bad;
    vecs[0] = '{5,  4,  1'b0, 0, 0, 0,  0, 7,  4,  3, 3};
    vecs[1] = '{9,  0,  1'b1, 1, 0, 0,  0, 1,  0,  0, 0};
    vecs[2] = '{63, 64, 1'b1, 1, 0, 0,  0, 67, 64, 3, 64};
    vecs[3] = '{2,  8,  1'b0, 1, 3, 10, 0, 21, 8,  3, 8};
    vecs[4] = '{0,  3,  1'b0, 3, 0, 0,  0, 5,  3,  3, 2};
    vecs[5] = '{17, 9,  1'b1, 2, 0, 0,  0, 12, 9,  3, 6};
    vecs[6] = '{3,  8,  1'b0, 1, 0, 0,  2, 11, 8,  3, 8};

    rst = 1'b1; pe_idx = '0; pe_start_broadcast = 1'b0; in_act_no = '0;
    act_regfile_dir = 1'b0; bcast_ready = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    check_reset_outputs("reset");
    rst = 1'b0;

    for (int t = 0; t < 7; t++) run_case(vecs[t], $sformatf("vec%0d", t));

    // Reset during DRAIN with both FIFO entries occupied (bank 1, 2 entries)
    begin
      vec_t r;
      r = '{7, 2, 1'b1, 1, 0, 0, 0, 0, 0, 0, 0};
      fill_banks(r);
      @(negedge clk);
      pe_idx = 6'd7; in_act_no = 7'd2; act_regfile_dir = 1'b1;
      pe_start_broadcast = 1'b1; bcast_ready = 1'b0;
      for (int cyc = 1; cyc <= 4; cyc++) begin
        @(negedge clk);
        pe_start_broadcast = 1'b0;
      end
      #1;
      check("rstdrain_valid", 64'(bcast_valid), 64'd1);
      check("rstdrain_head", 64'(bcast_data), 64'({6'd0, 6'd7, pat_val(1, 0)}));
      check("rstdrain_rd_dir", 64'(rd_dir), 64'd1);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      #1;
      check_reset_outputs("after_rst");
      bcast_ready = 1'b1;
      seen_bad = 1'b0;
      for (int k = 0; k < 5; k++) begin
        @(negedge clk); #1;
        if (broadcast_done || bcast_valid || busy) seen_bad = 1'b1;
      end
      check("after_rst_quiet", 64'(seen_bad), 64'd0);
    end

    // A fresh job after the mid-run reset
    run_case(vecs[0], "post_rst");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
